// File: rtl/line_buffer_pkg.sv
// Shared constants for the grayscale window path: pixel width and active line length
// (the latter is the same figure the VGA/camera timing uses for active pixels per line).
package line_buffer_pkg;

   localparam int DEFAULT_DATA_W     = 8;
   localparam int DEFAULT_LINE_WIDTH = 640;

   // Pointer width for a circular buffer of n entries; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_if.sv
// Pixel-stream bundle: one gray pixel in, eight window neighbours out (clockwise from top-left).
// No valid/ready: the stream advances on every clock and the neighbours are always presented.
interface line_buffer_if
   import line_buffer_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic [DATA_W-1:0] rgb_gray;
   logic [DATA_W-1:0] a0;
   logic [DATA_W-1:0] a1;
   logic [DATA_W-1:0] a2;
   logic [DATA_W-1:0] a3;
   logic [DATA_W-1:0] a4;
   logic [DATA_W-1:0] a5;
   logic [DATA_W-1:0] a6;
   logic [DATA_W-1:0] a7;

   modport master (
      output rgb_gray,
      input  a0, a1, a2, a3, a4, a5, a6, a7
   );

   modport slave (
      input  rgb_gray,
      output a0, a1, a2, a3, a4, a5, a6, a7
   );

endinterface

// File: rtl/line_buffer_line_delay.sv
// Fixed DEPTH-sample delay built on a circular RAM; reads are forced to zero until every
// slot has been written since reset, so nothing stored before reset can reach q.
module line_delay
   import line_buffer_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_LINE_WIDTH - 3,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic              filled;

   // The first wrap of the pointer marks the point where every slot holds post-reset data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         filled <= 1'b0;
      end else if (ptr == PTR_W'(DEPTH - 1)) begin
         ptr    <= '0;
         filled <= 1'b1;
      end else begin
         ptr    <= ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      mem[ptr] <= d;
   end

   // Read-before-write at the same slot yields the sample written DEPTH clocks ago.
   assign q = filled ? mem[ptr] : '0;

endmodule

// File: rtl/line_buffer.sv
// 3x3 window generator: three rows of three taps joined by two cascaded line delays so each
// row sits exactly LINE_WIDTH samples behind the row below it. Centre tap is kept but not output.
module line_buffer
   import line_buffer_pkg::*;
#(
   parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
   parameter int DATA_W     = DEFAULT_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   line_buffer_if.slave  bus
);

   logic [DATA_W-1:0] bot_r, bot_c, bot_l;
   logic [DATA_W-1:0] mid_r, mid_c, mid_l;
   logic [DATA_W-1:0] top_r, top_c, top_l;
   logic [DATA_W-1:0] bot_tail, mid_tail;

   // Three window taps plus LINE_WIDTH-3 delay slots make up one full line per row.
   line_delay #(
      .DEPTH  (LINE_WIDTH - 3),
      .DATA_W (DATA_W)
   ) u_delay_bot (
      .clk (clk),
      .rst (rst),
      .d   (bot_l),
      .q   (bot_tail)
   );

   line_delay #(
      .DEPTH  (LINE_WIDTH - 3),
      .DATA_W (DATA_W)
   ) u_delay_mid (
      .clk (clk),
      .rst (rst),
      .d   (mid_l),
      .q   (mid_tail)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bot_r <= '0;
         bot_c <= '0;
         bot_l <= '0;
         mid_r <= '0;
         mid_c <= '0;
         mid_l <= '0;
         top_r <= '0;
         top_c <= '0;
         top_l <= '0;
      end else begin
         bot_r <= bus.rgb_gray;
         bot_c <= bot_r;
         bot_l <= bot_c;
         mid_r <= bot_tail;
         mid_c <= mid_r;
         mid_l <= mid_c;
         top_r <= mid_tail;
         top_c <= top_r;
         top_l <= top_c;
      end
   end

   assign bus.a0 = top_l;
   assign bus.a1 = top_c;
   assign bus.a2 = top_r;
   assign bus.a3 = mid_r;
   assign bus.a4 = bot_r;
   assign bus.a5 = bot_c;
   assign bus.a6 = bot_l;
   assign bus.a7 = mid_l;

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: a narrow (4-pixel) and a full (640-pixel) instance are driven in
// lock-step; each output window is checked against a sample-history model of the stream.
module tb_line_buffer;
   import line_buffer_pkg::*;

   localparam int DW    = 8;
   localparam int WS    = 4;
   localparam int WB    = 640;
   localparam int WIN_W = 8 * DW;
   localparam int HMAX  = 2048;

   typedef struct {
      int               n;
      int               seg;
      logic [WIN_W-1:0] exp_s;
      logic [WIN_W-1:0] exp_b;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   line_buffer_if #(.DATA_W(DW)) bus_s ();
   line_buffer_if #(.DATA_W(DW)) bus_b ();

   line_buffer #(.LINE_WIDTH(WS), .DATA_W(DW)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s.slave)
   );

   line_buffer #(.LINE_WIDTH(WB), .DATA_W(DW)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   logic [WIN_W-1:0] act_s, act_b;
   assign act_s = {bus_s.a0, bus_s.a1, bus_s.a2, bus_s.a3, bus_s.a4, bus_s.a5, bus_s.a6, bus_s.a7};
   assign act_b = {bus_b.a0, bus_b.a1, bus_b.a2, bus_b.a3, bus_b.a4, bus_b.a5, bus_b.a6, bus_b.a7};

   // ---------------- reference model ----------------
   logic [DW-1:0] hs [HMAX];
   logic [DW-1:0] hb [HMAX];
   int            n_cur;
   int            seg;
   bit            running;
   exp_t          exp_q [$];
   int            tests;
   int            fails;

   function automatic logic [DW-1:0] tap(input bit big, input int k);
      if (k < 0) return '0;
      return big ? hb[k] : hs[k];
   endfunction

   // Window {a0..a7} after edge n: each neighbour is the stream sample a fixed distance back.
   function automatic logic [WIN_W-1:0] window(input bit big, input int n, input int w);
      return {tap(big, n - 2*w - 2), tap(big, n - 2*w - 1), tap(big, n - 2*w), tap(big, n - w),
              tap(big, n), tap(big, n - 1), tap(big, n - 2), tap(big, n - w - 2)};
   endfunction

   function automatic logic [WIN_W-1:0] fld(input logic [WIN_W-1:0] win, input int idx);
      return WIN_W'(win[(7 - idx) * DW +: DW]);
   endfunction

   task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [DW-1:0] xs);
      exp_t e;
      @(negedge clk);
      rst            = 1'b0;
      bus_s.rgb_gray = xs;
      bus_b.rgb_gray = 8'd125;
      hs[n_cur]      = xs;
      hb[n_cur]      = 8'd125;
      e.n            = n_cur;
      e.seg          = seg;
      e.exp_s        = window(1'b0, n_cur, WS);
      e.exp_b        = window(1'b1, n_cur, WB);
      exp_q.push_back(e);
      n_cur++;
      running = 1'b1;
   endtask

   // Reset asserted between edges with junk on the inputs; outputs must clear at once.
   task automatic start_segment(input int s);
      @(posedge clk);
      #3;
      rst            = 1'b1;
      running        = 1'b0;
      bus_s.rgb_gray = DW'($urandom_range(1, 255));
      bus_b.rgb_gray = DW'($urandom_range(1, 255));
      #1;
      check($sformatf("async_rst_small seg%0d", s), act_s, '0);
      check($sformatf("async_rst_big seg%0d", s), act_b, '0);
      @(posedge clk);
      #1;
      check($sformatf("rst_held_small seg%0d", s), act_s, '0);
      check($sformatf("rst_held_big seg%0d", s), act_b, '0);
      seg   = s;
      n_cur = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin
      exp_t cur;
      #1;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check($sformatf("model_small seg%0d n%0d", cur.seg, cur.n), act_s, cur.exp_s);
         check($sformatf("model_big seg%0d n%0d", cur.seg, cur.n), act_b, cur.exp_b);
         if (cur.seg <= 1) begin
            if (cur.n == 5)
               check("ramp_edge5", act_s, {8'd0, 8'd0, 8'd0, 8'd2, 8'd6, 8'd5, 8'd4, 8'd0});
            if (cur.n == 20)
               check("ramp_edge20", act_s, {8'd11, 8'd12, 8'd13, 8'd17, 8'd21, 8'd20, 8'd19, 8'd15});
         end
         if (cur.seg == 2) begin
            if (cur.n == 9)  check("step_a4_before", fld(act_s, 4), WIN_W'(8'd0));
            if (cur.n == 10) check("step_a4", fld(act_s, 4), WIN_W'(8'd255));
            if (cur.n == 13) check("step_a3_before", fld(act_s, 3), WIN_W'(8'd0));
            if (cur.n == 14) check("step_a3", fld(act_s, 3), WIN_W'(8'd255));
            if (cur.n == 15) check("step_a7_before", fld(act_s, 7), WIN_W'(8'd0));
            if (cur.n == 16) check("step_a7", fld(act_s, 7), WIN_W'(8'd255));
            if (cur.n == 19) check("step_a0_before", fld(act_s, 0), WIN_W'(8'd0));
            if (cur.n == 20) check("step_a0", fld(act_s, 0), WIN_W'(8'd255));
         end
         if (cur.seg == 0) begin
            if (cur.n == 0) begin
               check("big_a4_edge0", fld(act_b, 4), WIN_W'(8'd125));
               check("big_a3_edge0", fld(act_b, 3), WIN_W'(8'd0));
            end
            if (cur.n == 639)  check("big_a3_edge639", fld(act_b, 3), WIN_W'(8'd0));
            if (cur.n == 640)  check("big_a3_edge640", fld(act_b, 3), WIN_W'(8'd125));
            if (cur.n == 1281) check("big_a0_edge1281", fld(act_b, 0), WIN_W'(8'd0));
            if (cur.n == 1282) check("big_full_edge1282", act_b, {8{8'd125}});
            if (cur.n == 1299) check("big_full_edge1299", act_b, {8{8'd125}});
         end
      end else if (running) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      running        = 1'b0;
      tests          = 0;
      fails          = 0;
      seg            = 0;
      n_cur          = 0;
      bus_s.rgb_gray = '0;
      bus_b.rgb_gray = '0;
      #2;
      check("por_small", act_s, '0);
      check("por_big", act_b, '0);

      start_segment(0);
      for (int i = 0; i < 1300; i++) drive(DW'(i + 1));

      start_segment(1);
      for (int i = 0; i < 30; i++) drive(DW'(i + 1));

      start_segment(2);
      for (int i = 0; i < 25; i++) drive((i < 10) ? 8'd0 : 8'd255);

      start_segment(3);
      for (int i = 0; i < 50; i++) drive(DW'($urandom_range(0, 255)));

      @(posedge clk);
      #3;
      running = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
